// File: rtl/swipt_program_sequencer.sv
// rtl/swipt_program_sequencer.sv - SWIPT program FSM owning the frequency/duty set-points and the measurement window.
// "program" is a reserved word, so the state code leaves on program_code.
module swipt_program_sequencer #(
    parameter logic [19:0] START_FREQ    = 20'h08CA0,
    parameter logic [11:0] DUTY_DEFAULT  = 12'd200,
    parameter logic [11:0] DUTY_MAX      = 12'd500,
    parameter logic [11:0] DUTY_MIN      = 12'd50,
    parameter int          SETTLE_CYCLES = 5000000,
    parameter int          MEAS_CYCLES   = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swipt_alive,
    input  logic        comms_override,
    input  logic [19:0] comms_freq,
    input  logic [11:0] comms_duty,
    input  logic        freq_alg_done,
    input  logic [19:0] new_freq,
    input  logic [19:0] best_freq,
    input  logic        duty_step_valid,
    input  logic        duty_step_down,
    input  logic        mean_req,
    output logic [1:0]  program_code,
    output logic [19:0] freq,
    output logic [11:0] duty,
    output logic        measure,
    output logic        meas_done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FREQ_OPT = 2'b01,
        ST_MEASURE  = 2'b10,
        ST_DATA     = 2'b11
    } state_t;

    localparam logic [31:0] SETTLE_W = 32'(SETTLE_CYCLES);
    localparam logic [31:0] MEAS_END = 32'(SETTLE_CYCLES + MEAS_CYCLES);

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic [11:0] step;
    logic [12:0] duty_up;
    logic [12:0] duty_dn;
    logic [11:0] duty_stepped;
    logic [11:0] comms_duty_clamped;

    assign program_code = state;
    assign cnt_next     = cnt + 32'd1;

    // 13-bit sums so a large duty plus its step cannot wrap below the clamp.
    always_comb begin
        step         = duty / 12'd10;
        duty_up      = {1'b0, duty} + {1'b0, step};
        duty_dn      = {1'b0, duty} - {1'b0, step};
        duty_stepped = duty;
        if (duty_step_down)
            duty_stepped = (duty_dn > {1'b0, DUTY_MIN}) ? duty_dn[11:0] : DUTY_MIN;
        else
            duty_stepped = (duty_up < {1'b0, DUTY_MAX}) ? duty_up[11:0] : DUTY_MAX;
    end

    always_comb begin
        comms_duty_clamped = comms_duty;
        if (comms_duty < DUTY_MIN)
            comms_duty_clamped = DUTY_MIN;
        else if (comms_duty > DUTY_MAX)
            comms_duty_clamped = DUTY_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst || !swipt_alive) begin
            state     <= ST_IDLE;
            freq      <= START_FREQ;
            duty      <= DUTY_DEFAULT;
            measure   <= 1'b0;
            meas_done <= 1'b0;
            cnt       <= '0;
        end else if (comms_override) begin
            state     <= ST_IDLE;
            freq      <= comms_freq;
            duty      <= comms_duty_clamped;
            measure   <= 1'b0;
            meas_done <= 1'b0;
            cnt       <= '0;
        end else begin
            meas_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    measure <= 1'b0;
                    state   <= ST_FREQ_OPT;
                end
                ST_FREQ_OPT: begin
                    measure <= 1'b0;
                    if (freq_alg_done) begin
                        freq  <= best_freq;
                        cnt   <= '0;
                        state <= ST_MEASURE;
                    end else begin
                        freq <= new_freq;
                    end
                end
                // cnt holds the index of the current MEASURE cycle; outputs are set for the next one.
                ST_MEASURE: begin
                    cnt <= cnt_next;
                    if (cnt_next == MEAS_END) begin
                        state     <= ST_DATA;
                        measure   <= 1'b0;
                        meas_done <= 1'b1;
                    end else begin
                        measure <= (cnt_next >= SETTLE_W);
                    end
                end
                ST_DATA: begin
                    measure <= mean_req;
                    if (duty_step_valid)
                        duty <= duty_stepped;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_swipt_program_sequencer.sv
// tb/tb_swipt_program_sequencer.sv - self-checking bench for swipt_program_sequencer.
module tb_swipt_program_sequencer;

    logic        clk = 1'b0;
    logic        rst, swipt_alive, comms_override, freq_alg_done;
    logic        duty_step_valid, duty_step_down, mean_req;
    logic [19:0] comms_freq, new_freq, best_freq;
    logic [11:0] comms_duty;
    logic [1:0]  program_code;
    logic [19:0] freq;
    logic [11:0] duty;
    logic        measure, meas_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    swipt_program_sequencer #(.SETTLE_CYCLES(8), .MEAS_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .swipt_alive(swipt_alive), .comms_override(comms_override),
        .comms_freq(comms_freq), .comms_duty(comms_duty), .freq_alg_done(freq_alg_done),
        .new_freq(new_freq), .best_freq(best_freq), .duty_step_valid(duty_step_valid),
        .duty_step_down(duty_step_down), .mean_req(mean_req), .program_code(program_code),
        .freq(freq), .duty(duty), .measure(measure), .meas_done(meas_done)
    );

    function automatic logic [11:0] step_model(input int d, input bit down);
        int s = d / 10;
        int r;
        if (!down) r = (d + s < 500) ? d + s : 500;
        else       r = (d - s > 50) ? d - s : 50;
        return 12'(r);
    endfunction

    function automatic logic [11:0] clamp_model(input int d);
        return 12'((d < 50) ? 50 : (d > 500) ? 500 : d);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        rst = 1'b0; swipt_alive = 1'b1; comms_override = 1'b0; freq_alg_done = 1'b0;
        duty_step_valid = 1'b0; duty_step_down = 1'b0; mean_req = 1'b0;
        comms_freq = '0; comms_duty = '0; new_freq = '0; best_freq = '0;
    endtask

    // Override to set duty/freq, release, take the search result immediately: ends on MEASURE cycle 0.
    task automatic enter_measure(input logic [11:0] d, input logic [19:0] f);
        comms_override = 1'b1; comms_duty = d; comms_freq = f;
        tick;
        vectors++; if (duty !== clamp_model(d)) begin miscompares++; $display("FAIL ovr_duty: got %0d want %0d", duty, clamp_model(d)); end
        comms_override = 1'b0;
        tick;
        vectors++; if (program_code !== 2'b01) begin miscompares++; $display("FAIL release_prog: got %0d want 1", program_code); end
        freq_alg_done = 1'b1; best_freq = f + 20'd7; new_freq = f + 20'd3;
        tick;
        vectors++; if (freq !== f + 20'd7 || program_code !== 2'b10) begin miscompares++; $display("FAIL first_cycle_done: got freq %0d prog %0d want %0d 2", freq, program_code, f + 20'd7); end
        freq_alg_done = 1'b0;
    endtask

    task automatic reach_data(input logic [11:0] d, input logic [19:0] f);
        enter_measure(d, f);
        repeat (12) tick;
        vectors++; if (program_code !== 2'b11 || meas_done !== 1'b1) begin miscompares++; $display("FAIL reach_data: got prog %0d done %0b want 3 1", program_code, meas_done); end
    endtask

    task automatic test_reset;
        quiet(); rst = 1'b1;
        tick; tick;
        vectors++; if (program_code !== 2'b00) begin miscompares++; $display("FAIL reset_prog: got %0d want 0", program_code); end
        vectors++; if (freq !== 20'd36000) begin miscompares++; $display("FAIL reset_freq: got %0d want 36000", freq); end
        vectors++; if (duty !== 12'd200) begin miscompares++; $display("FAIL reset_duty: got %0d want 200", duty); end
        vectors++; if (measure !== 1'b0 || meas_done !== 1'b0) begin miscompares++; $display("FAIL reset_meas: got %0b%0b want 00", measure, meas_done); end
        rst = 1'b0;
    endtask

    task automatic test_freq_opt;
        tick;
        vectors++; if (program_code !== 2'b01) begin miscompares++; $display("FAIL idle_to_fopt: got %0d want 1", program_code); end
        for (int i = 0; i < 3; i++) begin
            new_freq = 20'(36100 + 100 * i); best_freq = 20'($urandom_range(1000, 90000));
            tick;
            vectors++; if (freq !== 20'(36100 + 100 * i) || program_code !== 2'b01) begin miscompares++; $display("FAIL fopt_track: got freq %0d prog %0d want %0d 1", freq, program_code, 36100 + 100 * i); end
        end
        freq_alg_done = 1'b1; best_freq = 20'd36200; new_freq = 20'd36400;
        tick;
        vectors++; if (freq !== 20'd36200 || program_code !== 2'b10 || measure !== 1'b0) begin miscompares++; $display("FAIL fopt_done: got freq %0d prog %0d meas %0b want 36200 2 0", freq, program_code, measure); end
        freq_alg_done = 1'b0;
    endtask

    // Starts on MEASURE cycle 0; inputs that belong to other states are randomised and must be ignored.
    task automatic test_measure;
        for (int k = 1; k <= 12; k++) begin
            freq_alg_done = 1'($urandom); duty_step_valid = 1'($urandom);
            mean_req = 1'($urandom); new_freq = 20'($urandom); best_freq = 20'($urandom);
            tick;
            if (k < 12) begin
                vectors++; if (program_code !== 2'b10 || measure !== (k >= 8) || meas_done !== 1'b0) begin miscompares++; $display("FAIL measure_window k=%0d: got prog %0d meas %0b done %0b want 2 %0b 0", k, program_code, measure, meas_done, k >= 8); end
                vectors++; if (freq !== 20'd36200 || duty !== 12'd200) begin miscompares++; $display("FAIL measure_hold: got %0d %0d want 36200 200", freq, duty); end
            end else begin
                vectors++; if (program_code !== 2'b11 || measure !== 1'b0 || meas_done !== 1'b1) begin miscompares++; $display("FAIL measure_end: got prog %0d meas %0b done %0b want 3 0 1", program_code, measure, meas_done); end
            end
        end
        quiet();
    endtask

    task automatic test_data_steps;
        logic [11:0] exp_duty;
        logic        exp_meas;
        duty_step_valid = 1'b1; duty_step_down = 1'b0; mean_req = 1'b1;
        tick;
        vectors++; if (duty !== 12'd220 || measure !== 1'b1 || meas_done !== 1'b0) begin miscompares++; $display("FAIL step_up_200: got duty %0d meas %0b done %0b want 220 1 0", duty, measure, meas_done); end
        exp_duty = 12'd220;
        for (int i = 0; i < 24; i++) begin
            duty_step_valid = 1'($urandom); duty_step_down = 1'($urandom); mean_req = 1'($urandom);
            if (duty_step_valid) exp_duty = step_model(exp_duty, duty_step_down);
            exp_meas = mean_req;
            tick;
            vectors++; if (duty !== exp_duty || measure !== exp_meas || program_code !== 2'b11) begin miscompares++; $display("FAIL data_random %0d: got duty %0d meas %0b prog %0d want %0d %0b 3", i, duty, measure, program_code, exp_duty, exp_meas); end
        end
        quiet();
        reach_data(12'd480, 20'd41000);
        duty_step_valid = 1'b1; duty_step_down = 1'b0;
        tick;
        vectors++; if (duty !== 12'd500) begin miscompares++; $display("FAIL step_up_480: got %0d want 500", duty); end
        tick;
        vectors++; if (duty !== 12'd500) begin miscompares++; $display("FAIL step_up_500: got %0d want 500", duty); end
        quiet();
        reach_data(12'd55, 20'd42000);
        duty_step_valid = 1'b1; duty_step_down = 1'b1;
        tick;
        vectors++; if (duty !== 12'd50) begin miscompares++; $display("FAIL step_down_55: got %0d want 50", duty); end
        quiet();
    endtask

    task automatic test_alive_drop;
        enter_measure(12'd300, 20'd45000);
        repeat (9) tick;
        vectors++; if (measure !== 1'b1) begin miscompares++; $display("FAIL pre_drop_meas: got %0b want 1", measure); end
        swipt_alive = 1'b0;
        tick;
        vectors++; if (program_code !== 2'b00 || freq !== 20'd36000 || duty !== 12'd200 || measure !== 1'b0) begin miscompares++; $display("FAIL alive_drop: got prog %0d freq %0d duty %0d meas %0b want 0 36000 200 0", program_code, freq, duty, measure); end
        freq_alg_done = 1'b1; best_freq = 20'd12345;
        tick;
        vectors++; if (program_code !== 2'b00 || freq !== 20'd36000) begin miscompares++; $display("FAIL alive_low_hold: got prog %0d freq %0d want 0 36000", program_code, freq); end
        swipt_alive = 1'b1; freq_alg_done = 1'b0;
        tick;
        vectors++; if (program_code !== 2'b01) begin miscompares++; $display("FAIL realive_fopt: got %0d want 1", program_code); end
        freq_alg_done = 1'b1; best_freq = 20'd37000;
        tick;
        freq_alg_done = 1'b0;
        repeat (7) tick;
        vectors++; if (program_code !== 2'b10 || measure !== 1'b0 || freq !== 20'd37000) begin miscompares++; $display("FAIL realive_settle: got prog %0d meas %0b freq %0d want 2 0 37000", program_code, measure, freq); end
        tick;
        vectors++; if (measure !== 1'b1) begin miscompares++; $display("FAIL realive_window: got %0b want 1", measure); end
    endtask

    task automatic test_override;
        comms_override = 1'b1; comms_freq = 20'd40000; comms_duty = 12'd600;
        tick;
        vectors++; if (freq !== 20'd40000 || duty !== 12'd500 || program_code !== 2'b00 || measure !== 1'b0) begin miscompares++; $display("FAIL override: got freq %0d duty %0d prog %0d meas %0b want 40000 500 0 0", freq, duty, program_code, measure); end
        for (int i = 0; i < 10; i++) begin
            comms_freq = 20'($urandom); comms_duty = 12'($urandom); freq_alg_done = 1'($urandom);
            tick;
            vectors++; if (freq !== comms_freq || duty !== clamp_model(comms_duty) || program_code !== 2'b00) begin miscompares++; $display("FAIL override_random %0d: got freq %0d duty %0d prog %0d want %0d %0d 0", i, freq, duty, program_code, comms_freq, clamp_model(comms_duty)); end
        end
        quiet();
        tick;
        vectors++; if (program_code !== 2'b01) begin miscompares++; $display("FAIL override_release: got %0d want 1", program_code); end
        reach_data(12'd300, 20'd43000);
        duty_step_valid = 1'b1; comms_override = 1'b1; comms_duty = 12'd250; comms_freq = 20'd44000;
        tick;
        vectors++; if (duty !== 12'd250 || program_code !== 2'b00) begin miscompares++; $display("FAIL override_vs_step: got duty %0d prog %0d want 250 0", duty, program_code); end
        quiet();
    endtask

    task automatic test_reset_in_data;
        reach_data(12'd400, 20'd50000);
        duty_step_valid = 1'b1; rst = 1'b1;
        tick;
        vectors++; if (duty !== 12'd200 || freq !== 20'd36000 || program_code !== 2'b00 || meas_done !== 1'b0) begin miscompares++; $display("FAIL reset_in_data: got duty %0d freq %0d prog %0d done %0b want 200 36000 0 0", duty, freq, program_code, meas_done); end
        quiet();
    endtask

    initial begin
        quiet();
        test_reset();
        test_freq_opt();
        test_measure();
        test_data_steps();
        test_alive_drop();
        test_override();
        test_reset_in_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
